// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps IDLE -> FETCH -> EXEC, computes the next
// instruction address for branches/jumps and raises one-cycle event pulses.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic [31:0] PC_in,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic [31:0] Rs_data,
  output logic [31:0] Next_PC,
  output logic        Phase,
  output logic        Branch_taken,
  output logic        Link_wr,
  output logic [31:0] Link_addr,
  output logic        Misalign,
  output logic        Halted
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] next_pc_next;
  logic [31:0] link_addr_next;
  logic        branch_next;
  logic        link_next;
  logic        misalign_next;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] seq_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] jr_pc;

  assign opcode    = Instr[31:26];
  assign funct     = Instr[5:0];
  assign seq_pc    = PC_in + 32'd4;
  assign branch_pc = seq_pc + {{14{Instr[15]}}, Instr[15:0], 2'b00};
  assign jump_pc   = {seq_pc[31:28], Instr[25:0], 2'b00};
  assign jr_pc     = {Rs_data[31:2], 2'b00};

  always_comb begin
    state_next     = state_reg;
    next_pc_next   = Next_PC;
    link_addr_next = Link_addr;
    branch_next    = 1'b0;
    link_next      = 1'b0;
    misalign_next  = 1'b0;

    if (!Stall) begin
      case (state_reg)
        S_IDLE:  state_next = S_FETCH;
        S_FETCH: state_next = S_EXEC;
        S_EXEC: begin
          next_pc_next = seq_pc;
          if (opcode == HALT_OPCODE) begin
            state_next = S_HALT;
          end else begin
            state_next = S_FETCH;
            case (opcode)
              OP_BEQ: begin
                if (Zero) begin
                  next_pc_next = branch_pc;
                  branch_next  = 1'b1;
                end
              end
              OP_BNE: begin
                if (!Zero) begin
                  next_pc_next = branch_pc;
                  branch_next  = 1'b1;
                end
              end
              OP_J: begin
                next_pc_next = jump_pc;
                branch_next  = 1'b1;
              end
              OP_JAL: begin
                next_pc_next   = jump_pc;
                branch_next    = 1'b1;
                link_next      = 1'b1;
                link_addr_next = seq_pc;
              end
              OP_SPECIAL: begin
                if (funct == FN_JR) begin
                  next_pc_next  = jr_pc;
                  branch_next   = 1'b1;
                  misalign_next = (Rs_data[1:0] != 2'b00);
                end
              end
              default: ;
            endcase
          end
        end
        default: ; // S_HALT: only reset leaves
      endcase
    end
  end

  // Phase and Halted are registered from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_reg    <= S_IDLE;
      Next_PC      <= RESET_PC;
      Phase        <= 1'b0;
      Branch_taken <= 1'b0;
      Link_wr      <= 1'b0;
      Link_addr    <= 32'h0000_0000;
      Misalign     <= 1'b0;
      Halted       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      Next_PC      <= next_pc_next;
      Phase        <= (state_next == S_EXEC);
      Branch_taken <= branch_next;
      Link_wr      <= link_next;
      Link_addr    <= link_addr_next;
      Misalign     <= misalign_next;
      Halted       <= (state_next == S_HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: an abstract reference model checked every cycle,
// plus directed instructions with hand-computed literal expectations.
module tb_pc_sequencer;

  logic        clk;
  logic        Reset;
  logic        Stall;
  logic [31:0] PC_in;
  logic [31:0] Instr;
  logic        Zero;
  logic [31:0] Rs_data;
  logic [31:0] Next_PC;
  logic        Phase;
  logic        Branch_taken;
  logic        Link_wr;
  logic [31:0] Link_addr;
  logic        Misalign;
  logic        Halted;

  int errors = 0;
  int checks = 0;
  bit check_en = 0;

  pc_sequencer dut (
    .clk(clk), .Reset(Reset), .Stall(Stall), .PC_in(PC_in), .Instr(Instr),
    .Zero(Zero), .Rs_data(Rs_data), .Next_PC(Next_PC), .Phase(Phase),
    .Branch_taken(Branch_taken), .Link_wr(Link_wr), .Link_addr(Link_addr),
    .Misalign(Misalign), .Halted(Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0=idle 1=fetch 2=exec 3=halt
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_link;
  logic        m_bt, m_lw, m_mis;

  function automatic bit is_jr(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] == 6'd8);
  endfunction

  function automatic bit model_taken(input logic [31:0] ins, input logic z);
    case (ins[31:26])
      6'd4:      return z;
      6'd5:      return !z;
      6'd2, 6'd3: return 1'b1;
      default:   return is_jr(ins);
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins,
                                               input logic z, input logic [31:0] rs);
    longint seq;
    longint off;
    seq = longint'(pc) + 4;
    off = 4 * longint'($signed(ins[15:0]));
    if (ins[31:26] == 6'h3F) return 32'(seq);
    if (!model_taken(ins, z)) return 32'(seq);
    if (ins[31:26] == 6'd4 || ins[31:26] == 6'd5) return 32'(seq + off);
    if (is_jr(ins)) return rs - (rs % 4);
    return 32'((seq / 268435456) % 16) * 32'h1000_0000 + 32'(ins[25:0]) * 4;
  endfunction

  always @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      m_mode <= 0; m_pc <= 32'h0; m_link <= 32'h0;
      m_bt <= 1'b0; m_lw <= 1'b0; m_mis <= 1'b0;
    end else begin
      m_bt <= 1'b0; m_lw <= 1'b0; m_mis <= 1'b0;
      if (!Stall) begin
        if (m_mode == 0 || m_mode == 1) begin
          m_mode <= m_mode + 1;
        end else if (m_mode == 2) begin
          m_pc <= model_target(PC_in, Instr, Zero, Rs_data);
          if (Instr[31:26] == 6'h3F) begin
            m_mode <= 3;
          end else begin
            m_mode <= 1;
            m_bt   <= model_taken(Instr, Zero);
            m_lw   <= (Instr[31:26] == 6'd3);
            m_mis  <= is_jr(Instr) && (Rs_data % 4 != 0);
            if (Instr[31:26] == 6'd3) m_link <= PC_in + 32'd4;
          end
        end
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check32("model_next_pc", Next_PC, m_pc);
      check32("model_link_addr", Link_addr, m_link);
      check1("model_phase", Phase, m_mode == 2);
      check1("model_halted", Halted, m_mode == 3);
      check1("model_branch_taken", Branch_taken, m_bt);
      check1("model_link_wr", Link_wr, m_lw);
      check1("model_misalign", Misalign, m_mis);
    end
  end

  // Called at a negedge in FETCH; returns at the negedge after the EXEC update.
  task automatic exec_instr(input logic [31:0] pc, input logic [31:0] ins,
                            input logic z, input logic [31:0] rs);
    PC_in = pc; Instr = ins; Zero = z; Rs_data = rs;
    @(posedge clk); @(negedge clk);
    check1("exec_phase", Phase, 1'b1);
    @(posedge clk); @(negedge clk);
    $display("exec pc=%h instr=%h zero=%b rs=%h -> next_pc=%h bt=%b lw=%b link=%h mis=%b halted=%b",
             pc, ins, z, rs, Next_PC, Branch_taken, Link_wr, Link_addr, Misalign, Halted);
  endtask

  initial begin
    Reset = 1'b0; Stall = 1'b0; PC_in = '0; Instr = '0; Zero = 1'b0; Rs_data = '0;
    @(negedge clk);
    check_en = 1;
    check32("reset_next_pc", Next_PC, 32'h0);
    check1("reset_phase", Phase, 1'b0);
    check1("reset_halted", Halted, 1'b0);
    check32("reset_link_addr", Link_addr, 32'h0);
    check1("reset_pulses", Branch_taken | Link_wr | Misalign, 1'b0);

    // release: IDLE now, FETCH after next edge, EXEC after the one after
    Reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check1("fetch_phase", Phase, 1'b0);
    check32("fetch_next_pc", Next_PC, 32'h0);

    exec_instr(32'h10, {6'b000100, 5'd1, 5'd2, 16'hFFFE}, 1'b1, 32'h0);
    check32("beq_taken_pc", Next_PC, 32'h0C);
    check1("beq_taken_bt", Branch_taken, 1'b1);

    exec_instr(32'h10, {6'b000100, 5'd1, 5'd2, 16'hFFFE}, 1'b0, 32'h0);
    check32("beq_not_taken_pc", Next_PC, 32'h14);
    check1("beq_not_taken_bt", Branch_taken, 1'b0);

    exec_instr(32'h40, {6'b000011, 26'h100}, 1'b0, 32'h0);
    check32("jal_pc", Next_PC, 32'h400);
    check32("jal_link", Link_addr, 32'h44);
    check1("jal_link_wr", Link_wr, 1'b1);
    check1("jal_bt", Branch_taken, 1'b1);
    exec_instr(32'h400, {6'b000100, 5'd1, 5'd2, 16'h0004}, 1'b1, 32'h0);
    check32("beq_fwd_pc", Next_PC, 32'h414);
    check1("link_wr_one_cycle", Link_wr, 1'b0);
    check32("link_addr_held", Link_addr, 32'h44);

    exec_instr(32'h80, {6'b000000, 5'd3, 15'd0, 6'b001000}, 1'b0, 32'h203);
    check32("jr_pc", Next_PC, 32'h200);
    check1("jr_misalign", Misalign, 1'b1);
    check1("jr_bt", Branch_taken, 1'b1);

    exec_instr(32'h100, {6'b000101, 5'd1, 5'd2, 16'h0010}, 1'b0, 32'h0);
    check32("bne_taken_pc", Next_PC, 32'h144);
    check1("bne_taken_bt", Branch_taken, 1'b1);

    exec_instr(32'h20, {6'b000100, 5'd1, 5'd2, 16'h0000}, 1'b1, 32'h0);
    check32("beq_to_seq_pc", Next_PC, 32'h24);
    check1("beq_to_seq_bt", Branch_taken, 1'b1);

    exec_instr(32'hFFFF_FFFC, {6'b001000, 5'd1, 5'd2, 16'h0005}, 1'b0, 32'h0);
    check32("wrap_pc", Next_PC, 32'h0);
    check1("wrap_no_flag", Branch_taken | Link_wr | Misalign, 1'b0);

    exec_instr(32'h7000_0000, {6'b000010, 26'h3FF_FFFF}, 1'b0, 32'h0);
    check32("j_region_pc", Next_PC, 32'h7FFF_FFFC);

    // stall for three cycles inside EXEC
    PC_in = 32'h0; Instr = {6'b000010, 26'h10}; Zero = 1'b0; Rs_data = 32'h0;
    @(posedge clk); @(negedge clk);
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check1("stall_phase", Phase, 1'b1);
      check32("stall_next_pc", Next_PC, 32'h7FFF_FFFC);
      check1("stall_bt", Branch_taken, 1'b0);
    end
    Stall = 1'b0;
    @(posedge clk); @(negedge clk);
    check32("post_stall_pc", Next_PC, 32'h40);
    check1("post_stall_bt", Branch_taken, 1'b1);
    check1("post_stall_phase", Phase, 1'b0);

    exec_instr(32'h80, {6'b111111, 26'h0}, 1'b0, 32'h0);
    check1("halt_level", Halted, 1'b1);
    check32("halt_pc", Next_PC, 32'h84);
    Instr = {6'b000010, 26'h55};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check32("halt_hold_pc", Next_PC, 32'h84);
      check1("halt_hold_level", Halted, 1'b1);
      check1("halt_no_pulse", Branch_taken, 1'b0);
    end

    // asynchronous reset between edges
    #2 Reset = 1'b0;
    #1;
    check32("async_reset_pc", Next_PC, 32'h0);
    check1("async_reset_halted", Halted, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check1("restart_fetch_phase", Phase, 1'b0);

    // reset mid-EXEC discards the pending jal
    PC_in = 32'h40; Instr = {6'b000011, 26'h100};
    @(posedge clk); @(negedge clk);
    check1("mid_exec_phase", Phase, 1'b1);
    #2 Reset = 1'b0;
    #1;
    check32("mid_exec_reset_pc", Next_PC, 32'h0);
    check1("mid_exec_reset_phase", Phase, 1'b0);
    @(negedge clk);
    Reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check32("mid_exec_link_clear", Link_addr, 32'h0);
    @(posedge clk); @(negedge clk);
    check1("restart_exec_phase", Phase, 1'b1);
    check32("restart_exec_pc", Next_PC, 32'h0);

    check_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
